// File: rtl/i2s_master_tx.sv
// -----------------------------------------------------------------------------
// i2s_master_tx
//
// Purpose:
//   I2S master transmitter in Philips format. Each frame is 64 sclk periods:
//   periods 0..31 carry the left channel (ws=0) and 32..63 the right channel
//   (ws=1). The 16-bit sample goes out MSB first, one sclk after the ws edge.
//   Bits past the 16-bit sample are zero. A single holding register decouples
//   the upstream write strobe from the frame timing.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active low
//   en         in   high = transmit frames, low = stop at the next frame end
//   wrt_smpl   in   one-clk strobe, captures lft_smpl/rght_smpl into hold
//   lft_smpl   in   left sample, two's complement
//   rght_smpl  in   right sample, two's complement
//   I2S_sclk   out  serial bit clock, period 2*SCLK_DIV clk
//   I2S_ws     out  word select, 0 = left, 1 = right
//   I2S_data   out  serial data, updated on the clk where sclk falls
//   frm_strt   out  one-clk pulse when hold is transferred to the shifters
//   undrn      out  one-clk pulse, frame loaded from a stale hold register
//   ovrn       out  one-clk pulse, write arrived while hold was still full
// -----------------------------------------------------------------------------
module i2s_master_tx #(
   parameter  int SCLK_DIV = 16,
   localparam int DATA_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     wrt_smpl,
   input  logic signed [DATA_W-1:0] lft_smpl,
   input  logic signed [DATA_W-1:0] rght_smpl,
   output logic                     I2S_sclk,
   output logic                     I2S_ws,
   output logic                     I2S_data,
   output logic                     frm_strt,
   output logic                     undrn,
   output logic                     ovrn
);

   localparam int              DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t                     state_q, state_d;
   logic [DIV_W-1:0]           div_cnt_q, div_cnt_d;
   logic [5:0]                 bit_cnt_q, bit_cnt_d;
   logic                       sclk_q, sclk_d;
   logic                       ws_q, ws_d;
   logic                       data_q, data_d;
   logic                       frm_q, frm_d;
   logic                       undrn_q, undrn_d;
   logic                       ovrn_q, ovrn_d;
   logic signed [DATA_W-1:0]   hold_l_q, hold_l_d;
   logic signed [DATA_W-1:0]   hold_r_q, hold_r_d;
   logic                       hold_full_q, hold_full_d;
   logic signed [DATA_W-1:0]   shft_l_q, shft_l_d;
   logic signed [DATA_W-1:0]   shft_r_q, shft_r_d;

   logic active;     // divider running (RUN or DRAIN)
   logic tc;         // divider terminal count, sclk toggles this clk
   logic fall;       // sclk goes 1->0 this clk
   logic frame_end;  // falling edge that closes period 63
   logic keep_run;   // another frame follows the one that is ending
   logic load;       // hold -> shifters transfer this clk

   assign active    = (state_q != IDLE);
   assign tc        = active && (div_cnt_q == DIV_TC);
   assign fall      = tc && sclk_q;
   assign frame_end = fall && (bit_cnt_q == 6'd63);
   // A DRAIN whose en came back before the frame end behaves as RUN here,
   // so the frame boundary is not lost.
   assign keep_run  = (state_q == RUN) || en;
   assign load      = frame_end && keep_run;

   always_comb begin
      state_d     = state_q;
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      sclk_d      = sclk_q;
      ws_d        = ws_q;
      data_d      = data_q;
      frm_d       = 1'b0;
      undrn_d     = 1'b0;
      ovrn_d      = 1'b0;
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;
      hold_full_d = hold_full_q;
      shft_l_d    = shft_l_q;
      shft_r_d    = shft_r_q;

      case (state_q)
         IDLE:    if (en) state_d = RUN;
         RUN:     if (!en) state_d = DRAIN;
         DRAIN: begin
            if (frame_end && !en) state_d = IDLE;
            else if (en)          state_d = RUN;
         end
         default: state_d = IDLE;
      endcase

      // sclk divider; parked low with a cleared count while idle
      if (!active) begin
         div_cnt_d = '0;
         sclk_d    = 1'b0;
      end else if (tc) begin
         div_cnt_d = '0;
         sclk_d    = ~sclk_q;
      end else begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end

      if (fall) begin
         if (frame_end && !keep_run) begin
            // Stopping: bit_cnt stays at 63 so a restart begins with a load.
            ws_d   = 1'b1;
            data_d = 1'b0;
         end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            ws_d      = bit_cnt_d[5];
            data_d    = 1'b0;
            if ((bit_cnt_d >= 6'd1) && (bit_cnt_d <= 6'd16)) begin
               data_d   = shft_l_q[DATA_W-1];
               shft_l_d = {shft_l_q[DATA_W-2:0], 1'b0};
            end else if ((bit_cnt_d >= 6'd33) && (bit_cnt_d <= 6'd48)) begin
               data_d   = shft_r_q[DATA_W-1];
               shft_r_d = {shft_r_q[DATA_W-2:0], 1'b0};
            end
            if (load) begin
               shft_l_d    = hold_l_q;
               shft_r_d    = hold_r_q;
               frm_d       = 1'b1;
               undrn_d     = ~hold_full_q;
               hold_full_d = 1'b0;
            end
         end
      end

      // A write on the load clk lands in hold after the shifters took the
      // old contents, so it counts as fresh data rather than an overrun.
      if (wrt_smpl) begin
         hold_l_d    = lft_smpl;
         hold_r_d    = rght_smpl;
         hold_full_d = 1'b1;
         ovrn_d      = hold_full_q && !load;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         div_cnt_q   <= '0;
         bit_cnt_q   <= 6'd63;
         sclk_q      <= 1'b0;
         ws_q        <= 1'b1;
         data_q      <= 1'b0;
         frm_q       <= 1'b0;
         undrn_q     <= 1'b0;
         ovrn_q      <= 1'b0;
         hold_l_q    <= '0;
         hold_r_q    <= '0;
         hold_full_q <= 1'b0;
         shft_l_q    <= '0;
         shft_r_q    <= '0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         sclk_q      <= sclk_d;
         ws_q        <= ws_d;
         data_q      <= data_d;
         frm_q       <= frm_d;
         undrn_q     <= undrn_d;
         ovrn_q      <= ovrn_d;
         hold_l_q    <= hold_l_d;
         hold_r_q    <= hold_r_d;
         hold_full_q <= hold_full_d;
         shft_l_q    <= shft_l_d;
         shft_r_q    <= shft_r_d;
      end
   end

   assign I2S_sclk = sclk_q;
   assign I2S_ws   = ws_q;
   assign I2S_data = data_q;
   assign frm_strt = frm_q;
   assign undrn    = undrn_q;
   assign ovrn     = ovrn_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_master_tx
//
// Bench for i2s_master_tx with SCLK_DIV=4. The reference model works at the
// frame level: frames load every 128*SCLK_DIV clk starting 2*SCLK_DIV clk
// after enable, a load takes the current hold contents, and complete frames
// seen on the wire are compared with the expected 64-bit frame image.
// -----------------------------------------------------------------------------
module tb_i2s_master_tx;

   localparam int D  = 4;
   localparam int FR = 128 * D;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b1;
   logic        en        = 1'b0;
   logic        wrt_smpl  = 1'b0;
   logic [15:0] lft_smpl  = '0;
   logic [15:0] rght_smpl = '0;
   logic        I2S_sclk, I2S_ws, I2S_data, frm_strt, undrn, ovrn;

   i2s_master_tx #(.SCLK_DIV(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .wrt_smpl  (wrt_smpl),
      .lft_smpl  (lft_smpl),
      .rght_smpl (rght_smpl),
      .I2S_sclk  (I2S_sclk),
      .I2S_ws    (I2S_ws),
      .I2S_data  (I2S_data),
      .frm_strt  (frm_strt),
      .undrn     (undrn),
      .ovrn      (ovrn)
   );

   always #5 clk = ~clk;

   int vec = 0, errs = 0, cyc = 0;

   // reference model state
   logic [15:0] m_hl = '0, m_hr = '0;
   bit          m_full = 1'b0, m_act = 1'b0, m_started = 1'b0;
   int          m_nload = 0;
   logic [31:0] exp_q[$];

   // observation state
   bit          cap_on = 1'b0;
   int          cap_n = 0;
   logic [63:0] cap_d = '0, cap_w = '0, last_frame = '0, prev_frame = '0;
   logic        sclk_prev = 1'b0;
   bit          rise_vld = 1'b0;
   int          last_rise = 0;
   int          frames_done = 0, frm_cnt = 0, undrn_cnt = 0, ovrn_cnt = 0;
   int          last_frm_cyc = 0;
   int          frm_hist[$];

   function automatic logic [63:0] frame_of(logic [31:0] e);
      return {1'b0, e[31:16], 16'h0000, e[15:0], 15'h0000};
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling clk edge; the rising edge just passed used
   // the inputs that are still applied, so the model steps with them here.
   task automatic tick();
      bit          ld, full_pre;
      logic        exp_u, exp_o;
      logic [31:0] e;
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         chk("rst_sclk", I2S_sclk, 0);
         chk("rst_ws", I2S_ws, 1);
         chk("rst_data", I2S_data, 0);
         chk("rst_pulses", {frm_strt, undrn, ovrn}, 0);
         sclk_prev = I2S_sclk;
         return;
      end
      ld = 1'b0; exp_u = 1'b0; exp_o = 1'b0; full_pre = m_full;
      if (m_act && cyc == m_nload) begin
         if (en) begin
            ld = 1'b1;
            exp_q.push_back({m_hl, m_hr});
            exp_u = !m_full;
            m_full = 1'b0;
            m_started = 1'b1;
            m_nload += FR;
         end else begin
            m_act = 1'b0;
            rise_vld = 1'b0;
         end
      end else if (!m_act && en) begin
         m_act = 1'b1;
         m_started = 1'b0;
         m_nload = cyc + 2 * D;
         rise_vld = 1'b0;
      end
      if (wrt_smpl) begin
         exp_o = full_pre && !ld;
         m_hl = lft_smpl;
         m_hr = rght_smpl;
         m_full = 1'b1;
      end
      chk("frm_strt", frm_strt, ld);
      chk("undrn", undrn, exp_u);
      chk("ovrn", ovrn, exp_o);
      if (ld) chk("ws_low_at_load", I2S_ws, 0);
      if (!m_act) begin
         chk("idle_sclk", I2S_sclk, 0);
         chk("idle_ws", I2S_ws, 1);
         chk("idle_data", I2S_data, 0);
      end else if (!m_started) begin
         chk("start_ws", I2S_ws, 1);
         chk("start_data", I2S_data, 0);
      end
      if (frm_strt) begin
         frm_cnt++;
         last_frm_cyc = cyc;
         frm_hist.push_back(cyc);
         cap_on = 1'b1;
         cap_n = 0;
      end
      if (undrn) undrn_cnt++;
      if (ovrn) ovrn_cnt++;
      if (I2S_sclk && !sclk_prev) begin
         if (rise_vld) chk("sclk_period", cyc - last_rise, 2 * D);
         last_rise = cyc;
         rise_vld = 1'b1;
         if (cap_on) begin
            cap_d = {cap_d[62:0], I2S_data};
            cap_w = {cap_w[62:0], I2S_ws};
            cap_n++;
            if (cap_n == 64) begin
               cap_on = 1'b0;
               prev_frame = last_frame;
               last_frame = cap_d;
               chk("frame_pending", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("frame_data", cap_d, frame_of(e));
                  chk("frame_ws", cap_w, {32'h0000_0000, 32'hFFFF_FFFF});
               end
               frames_done++;
            end
         end
      end
      sclk_prev = I2S_sclk;
   endtask

   task automatic write(logic [15:0] l, logic [15:0] r);
      lft_smpl  = l;
      rght_smpl = r;
      wrt_smpl  = 1'b1;
      tick();
      wrt_smpl  = 1'b0;
   endtask

   task automatic wait_frm();
      int n0, t0;
      n0 = frm_cnt;
      t0 = cyc;
      while (frm_cnt == n0 && cyc - t0 < 2 * FR) tick();
      chk("wait_frm_strt", frm_cnt - n0, 1);
   endtask

   task automatic wait_frames(int target, int budget);
      int t0;
      t0 = cyc;
      while (frames_done < target && cyc - t0 < budget) tick();
      chk("wait_frames", frames_done, target);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_sclk", I2S_sclk, 0);
      chk("async_rst_ws", I2S_ws, 1);
      chk("async_rst_data", I2S_data, 0);
      chk("async_rst_pulses", {frm_strt, undrn, ovrn}, 0);
      m_hl = '0; m_hr = '0; m_full = 1'b0; m_act = 1'b0; m_started = 1'b0;
      exp_q.delete();
      cap_on = 1'b0; cap_n = 0; rise_vld = 1'b0; sclk_prev = 1'b0;
   endtask

   initial begin
      int          ce, fd, fc, u0, o0, L, r, t0;
      logic [15:0] rl, rr;

      // power-on reset, checked before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("por_sclk", I2S_sclk, 0);
      chk("por_ws", I2S_ws, 1);
      chk("por_data", I2S_data, 0);
      chk("por_pulses", {frm_strt, undrn, ovrn}, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // basic frame, then two repeated frames with underrun
      write(16'hA5C3, 16'h3C5A);
      en = 1'b1;
      ce = cyc;
      frm_hist.delete();
      wait_frames(1, 3 * FR);
      chk("frame1_bits", last_frame, 64'h52E1_8000_1E2D_0000);
      // ce+1 is the first clk edge that sees en high
      chk("ws_fall_delay", frm_hist[0] - (ce + 1), 2 * D);
      wait_frames(3, 3 * FR);
      chk("frm_interval_1", frm_hist[1] - frm_hist[0], FR);
      chk("frm_interval_2", frm_hist[2] - frm_hist[1], FR);
      chk("undrn_count_3frames", undrn_cnt, 2);
      chk("frame3_bits", last_frame, 64'h52E1_8000_1E2D_0000);

      // two writes in one frame: overrun, newest wins
      wait_frm();
      repeat (20) tick();
      o0 = ovrn_cnt;
      write(16'h1111, 16'hEEEE);
      repeat (20) tick();
      write(16'h2222, 16'hDDDD);
      chk("ovrn_on_second", ovrn_cnt - o0, 1);
      fd = frames_done;
      wait_frames(fd + 2, 3 * FR);
      chk("after_ovrn_left", last_frame[62:47], 16'h2222);
      chk("after_ovrn_right", last_frame[30:15], 16'hDDDD);

      // write on the same clk as a frame load
      while (cyc < m_nload - 1) tick();
      u0 = undrn_cnt;
      o0 = ovrn_cnt;
      fd = frames_done;
      write(16'h7FFF, 16'h8001);
      chk("coinc_frm_strt", frm_strt, 1);
      wait_frames(fd + 2, 3 * FR);
      chk("coinc_old_frame", prev_frame, frame_of({16'h2222, 16'hDDDD}));
      chk("coinc_new_frame", last_frame, frame_of({16'h7FFF, 16'h8001}));
      chk("coinc_undrn", undrn_cnt - u0, 1);
      chk("coinc_ovrn", ovrn_cnt - o0, 0);

      // drop en in period 20: frame completes, then idle; restart
      wait_frm();
      L = last_frm_cyc;
      while (cyc < L + 20 * 2 * D + 2) tick();
      en = 1'b0;
      fd = frames_done;
      fc = frm_cnt;
      wait_frames(fd + 1, 2 * FR);
      repeat (2 * FR) tick();
      chk("stop_no_frm", frm_cnt - fc, 0);
      chk("stop_sclk", I2S_sclk, 0);
      chk("stop_ws", I2S_ws, 1);
      chk("stop_data", I2S_data, 0);
      en = 1'b1;
      ce = cyc;
      wait_frm();
      chk("restart_delay", last_frm_cyc - (ce + 1), 2 * D);

      // reset in period 40 while sclk and data are high
      write(16'hC0DE, 16'h0F00);
      wait_frm();
      L = last_frm_cyc;
      while (cyc < L + 40 * 2 * D + D + 1) tick();
      chk("pre_reset_sclk", I2S_sclk, 1);
      chk("pre_reset_data", I2S_data, 1);
      do_reset();
      repeat (4) tick();
      rst_n = 1'b1;
      r = cyc;
      rl = 16'($urandom);
      rr = 16'($urandom);
      u0 = undrn_cnt;
      fd = frames_done;
      write(rl, rr);
      wait_frm();
      chk("post_reset_delay", last_frm_cyc - (r + 1), 2 * D);
      chk("post_reset_undrn", undrn_cnt - u0, 0);
      wait_frames(fd + 1, 2 * FR);
      chk("post_reset_frame", last_frame, frame_of({rl, rr}));

      // randomized writes against the model
      repeat (4000) begin
         if ($urandom_range(0, 199) == 0) write(16'($urandom), 16'($urandom));
         else tick();
      end
      en = 1'b0;
      t0 = cyc;
      while (m_act && cyc - t0 < 2 * FR) tick();
      repeat (10) tick();
      chk("all_frames_seen", exp_q.size(), 0);
      chk("final_sclk", I2S_sclk, 0);
      chk("final_ws", I2S_ws, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/i2s_master_tx.md
Name: i2s_master_tx

Overview:
- I2S master transmitter: takes parallel 16-bit left/right samples from the equalizer back end and serializes them onto I2S_sclk/I2S_ws/I2S_data. Philips format: 64 sclk per frame, 32 per channel, MSB first, data delayed one sclk after the ws edge.
- Outbound counterpart of I2S_Slave. Drives the codec/DAC path and the loopback benches.
- One holding register (double buffer) decouples the upstream write strobe from the frame timing.

Parameters:
- SCLK_DIV, 16, clk cycles per sclk half-period (sclk period = 2*SCLK_DIV clk); legal ≥2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active low.
- en  input  1  level; high = transmit frames, low = stop at the next frame boundary.
- wrt_smpl  input  1  one-clk strobe; capture lft_smpl/rght_smpl into the holding register.
- lft_smpl  input  16  left sample, two's complement.
- rght_smpl  input  16  right sample, two's complement.
- I2S_sclk  output  1  serial bit clock.
- I2S_ws  output  1  word select; 0 = left, 1 = right.
- I2S_data  output  1  serial data; changes on sclk falling edge.
- frm_strt  output  1  one-clk pulse when the holding register is transferred to the shifter.
- undrn  output  1  one-clk pulse: frame loaded with no fresh sample (previous sample repeated).
- ovrn  output  1  one-clk pulse: wrt_smpl arrived while the holding register was still full.

Behaviour:
- Reset values:
  - Outputs: I2S_sclk=0, I2S_ws=1, I2S_data=0, frm_strt=undrn=ovrn=0.
  - Internal: state=IDLE, div_cnt=0, bit_cnt=63, hold=0, hold_full=0, shifters=0.
- States IDLE, RUN, DRAIN:
  - IDLE→RUN when en=1.
  - RUN→DRAIN when en=0.
  - DRAIN→RUN if en returns to 1 before the frame ends.
  - DRAIN→IDLE at the falling edge ending period 63. I2S_ws=1 and I2S_data=0 at that point; no load happens and frm_strt is not pulsed.
  - In IDLE: div_cnt held at 0, sclk held low, bit_cnt=63.
- Divider (RUN/DRAIN):
  - div_cnt counts 0..SCLK_DIV-1. At terminal count it wraps and I2S_sclk toggles, registered.
  - First sclk rise comes SCLK_DIV clks after entering RUN; first fall at 2*SCLK_DIV.
- Falling-edge actions (the clk on which sclk goes 1→0). All of the following happen registered in that same clk:
  - bit_cnt increments mod 64.
  - I2S_ws = (new bit_cnt ≥ 32).
  - I2S_data for period n:
    - n=1..16: left bit 16-n (MSB at n=1).
    - n=33..48: right bit 48-n.
    - all other n: 0.
- Frame load (bit_cnt 63→0):
  - Shifters are loaded from hold; frm_strt pulses.
  - If hold_full=0, hold is reused and undrn pulses with frm_strt.
  - hold_full clears.
- Holding register:
  - wrt_smpl loads hold and sets hold_full.
  - If hold_full is already 1 and no frame load occurs in the same clk: newest sample wins and ovrn pulses.
  - wrt_smpl in the same clk as a frame load: the shifter gets the old hold contents, the new sample is written to hold, hold_full ends at 1, and no ovrn.
- wrt_smpl is accepted in every state, including IDLE.
- Sample values are passed through unmodified: no rounding or width change.
- Reset mid-frame: all outputs return immediately (asynchronously) to reset values; no partial-frame completion.

Test Plan:
- SCLK_DIV=4, write L=16'hA5C3, R=16'h3C5A, then en=1:
  - ws falls at clk 8 after en.
  - sclk period is 8 clk.
  - Data sampled on sclk rises during periods 1..16 reads 1010_0101_1100_0011; periods 33..48 read 0011_1100_0101_1010; all other bits 0.
  - frm_strt pulses once per 512 clk.
- Write once, run 3 frames:
  - Frames 2 and 3 repeat A5C3/3C5A.
  - undrn pulses coincide with frm_strt at frames 2 and 3 only.
- Two wrt_smpl (16'h1111, then 16'h2222) within one frame: ovrn pulses on the second; the next frame sends 16'h2222.
- wrt_smpl coincident with the frm_strt clk (L=16'h7FFF):
  - The current frame sends the old hold contents.
  - The next frame sends 7FFF with no undrn and no ovrn.
- en dropped at period 20:
  - Frame completes through period 63.
  - Then sclk stays 0, ws 1, data 0, no further frm_strt.
  - Re-raising en restarts with ws falling 2*SCLK_DIV clk later.
- rst_n asserted at period 40: outputs go 0/1/0 asynchronously. After release with en=1, the first frame starts cleanly at period 0.
